sync_fifo_pro: RTL and testbench

//  Parametrised single-clock FIFO; next generation of our synchronous FIFO.
//  - All DEPTH entries are usable.
//  - Adds occupancy count, programmable almost-full/almost-empty, and sticky

---
 rtl/sync_fifo_pkg.sv | 21 ++
 rtl/sync_fifo_mem.sv | 25 ++
 rtl/sync_fifo_pro.sv | 127 ++++++++++++
 tb/tb_sync_fifo_pro.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo_pro FIFO.
package sync_fifo_pkg;

  // Address width for a given depth (pointers carry one extra wrap bit).
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Returns 1 when n is a power of two.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO with count, programmable almost flags and sticky errors.
// Define SYNC_FIFO_PRO_FWFT_EN for first-word-fall-through read mode;
// otherwise reads are registered with one cycle of latency.
module sync_fifo_pro
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        w_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        r_en,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        data_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic                        underflow,
  input  logic                        err_clr
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_LEVEL);

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_pro: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_pro: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_pro: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_acc, wr_acc;
  fifo_status_t          st;

  // Status decoded from registered pointers/count; MSB mismatch means wrapped.
  assign st.full         = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                           (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign st.empty        = (wr_ptr == rd_ptr);
  assign st.almost_full  = (cnt >= AF_C);
  assign st.almost_empty = (cnt <= AE_C);

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign count        = cnt;

  // A full FIFO still takes a write when a read frees a slot this cycle.
  assign rd_acc = r_en & ~st.empty;
  assign wr_acc = w_en & (~st.full | rd_acc);

  sync_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[PTR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[PTR_W-1:0]),
    .rdata (rd_data)
  );

  // Pointers and occupancy; power-of-two depth lets the wrap bit toggle naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky error flags; a new error in the clear cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (w_en & ~wr_acc) | (overflow  & ~err_clr);
      underflow <= (r_en & st.empty) | (underflow & ~err_clr);
    end
  end

`ifdef SYNC_FIFO_PRO_FWFT_EN
  // Head word is presented directly; r_en acknowledges it.
  assign data_out   = rd_data;
  assign data_valid = ~st.empty;
`else
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dv_q;

  // Registered read: popped word appears the cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      dv_q <= rd_acc;
      if (rd_acc) dout_q <= rd_data;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
`endif

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Bench for sync_fifo_pro: constant vector table, hand sequences, and
// randomized traffic checked against a queue-based reference model.
module tb_sync_fifo_pro;

  localparam int DW = 8, DEPTH = 8, AF = 6, AE = 2;
`ifdef SYNC_FIFO_PRO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] data_in = '0, data_out;
  logic data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [$clog2(DEPTH):0] count;

  sync_fifo_pro #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Reference model: a queue plus the spec's acceptance rules.
  logic [DW-1:0] m_q[$];
  logic m_ovf = 0, m_udf = 0, m_dv = 0;
  logic [DW-1:0] m_out = '0;

  task automatic model_reset();
    m_q.delete(); m_ovf = 0; m_udf = 0; m_dv = 0; m_out = '0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
    bit was_empty, ra, wa;
    was_empty = (m_q.size() == 0);
    ra = r && !was_empty;
    wa = w && (m_q.size() < DEPTH || ra);
    m_ovf = (w && !wa) ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_udf = (r && was_empty) ? 1'b1 : (c ? 1'b0 : m_udf);
    if (ra) begin
      if (!FWFT) m_out = m_q[0];
      void'(m_q.pop_front());
    end
    if (wa) m_q.push_back(d);
    if (FWFT) begin
      m_dv = (m_q.size() != 0);
      if (m_dv) m_out = m_q[0];
    end else begin
      m_dv = ra;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    int sz;
    sz = m_q.size();
    chk({tag, ".count"}, int'(count), sz);
    chk({tag, ".full"}, int'(full), int'(sz == DEPTH));
    chk({tag, ".empty"}, int'(empty), int'(sz == 0));
    chk({tag, ".af"}, int'(almost_full), int'(sz >= AF));
    chk({tag, ".ae"}, int'(almost_empty), int'(sz <= AE));
    chk({tag, ".ovf"}, int'(overflow), int'(m_ovf));
    chk({tag, ".udf"}, int'(underflow), int'(m_udf));
    chk({tag, ".dv"}, int'(data_valid), int'(m_dv));
    if (!FWFT || m_dv) chk({tag, ".dout"}, int'(data_out), int'(m_out));
  endtask

  // One clock with the given inputs; outputs are valid #1 after the edge.
  task automatic cyc(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
    w_en = w; r_en = r; err_clr = c; data_in = d;
    @(posedge clk);
    model_step(w, r, c, d);
    #1;
    w_en = 0; r_en = 0; err_clr = 0;
  endtask

  typedef struct {
    logic w, r, c;
    logic [DW-1:0] d;
    int cnt;
    logic full, empty, af, ae, ovf, udf, dv;
    logic [DW-1:0] dout;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic w, logic r, logic c, logic [DW-1:0] d, int cnt,
                              logic ovf, logic dv, logic [DW-1:0] dout);
    vec_t v;
    v.w = w; v.r = r; v.c = c; v.d = d; v.cnt = cnt;
    v.full = (cnt == DEPTH); v.empty = (cnt == 0);
    v.af = (cnt >= AF); v.ae = (cnt <= AE);
    v.ovf = ovf; v.udf = 1'b0; v.dv = dv; v.dout = dout;
    return v;
  endfunction

  initial begin
    // Fill 01..08, reject a write at full, clear, write+read at full, drain.
    for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, 0, 0, 8'(i), i, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'hFF, 8, 1, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'h00, 8, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 0, 8'hAA, 8, 0, 1, 8'h01));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0, 1, 0, 8'h00, 8 - k, 0, 1, (k < 8) ? 8'(k + 1) : 8'hAA));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", int'(count), 0);
    chk("rst.empty", int'(empty), 1);
    chk("rst.ae", int'(almost_empty), 1);
    chk("rst.full", int'(full), 0);
    chk("rst.af", int'(almost_full), 0);
    chk("rst.ovf", int'(overflow), 0);
    chk("rst.udf", int'(underflow), 0);
    chk("rst.dv", int'(data_valid), 0);
    if (!FWFT) chk("rst.dout", int'(data_out), 0);
    rst_n = 1'b1;
    model_reset();

    // Table vectors
    foreach (tbl[i]) begin
      cyc(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
      chk($sformatf("tbl%0d.count", i), int'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d.flags", i), int'({full, empty, almost_full, almost_empty}),
          int'({tbl[i].full, tbl[i].empty, tbl[i].af, tbl[i].ae}));
      chk($sformatf("tbl%0d.err", i), int'({overflow, underflow}), int'({tbl[i].ovf, tbl[i].udf}));
      if (!FWFT) begin
        chk($sformatf("tbl%0d.dv", i), int'(data_valid), int'(tbl[i].dv));
        chk($sformatf("tbl%0d.dout", i), int'(data_out), int'(tbl[i].dout));
      end
      chk_model($sformatf("tblm%0d", i));
    end

    // Interleaved writes/reads across pointer wrap
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 8'(8'h30 + i)); chk_model("wrap.w");
      cyc(0, 1, 0, 8'h00);         chk_model("wrap.r");
    end
    chk("wrap.empty", int'(empty), 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
          1'($urandom_range(0, 19) == 0), 8'($urandom));
      chk_model("rnd");
    end

    // Drain (bounded), clear errors, then read while empty
    for (int i = 0; i <= DEPTH && m_q.size() != 0; i++) cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'h00);
    chk("drain.empty", int'(empty), 1);
    cyc(0, 1, 0, 8'h00);
    chk("udf.flag", int'(underflow), 1);
    chk("udf.dv", int'(data_valid), 0);
    chk("udf.count", int'(count), 0);
    cyc(1, 1, 0, 8'h77);
    chk("wr_rd_empty.count", int'(count), 1);
    chk_model("wr_rd_empty");
    cyc(0, 1, 0, 8'h00);
    chk_model("pop77");

`ifdef SYNC_FIFO_PRO_FWFT_EN
    // Fall-through: word visible without r_en, r_en retires it
    cyc(1, 0, 0, 8'h5A);
    chk("fwft.dv", int'(data_valid), 1);
    chk("fwft.dout", int'(data_out), 8'h5A);
    cyc(0, 1, 0, 8'h00);
    chk("fwft.empty", int'(empty), 1);
    chk("fwft.dv0", int'(data_valid), 0);
`endif

    // Asynchronous reset mid-operation at count=5
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(8'hC0 + i));
    cyc(1, 1, 0, 8'hC5);
    chk("pre_rst.count", int'(count), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.count", int'(count), 0);
    chk("arst.flags", int'({full, empty, almost_full, almost_empty}), int'(4'b0101));
    chk("arst.err", int'({overflow, underflow}), 0);
    chk("arst.dv", int'(data_valid), 0);
    if (!FWFT) chk("arst.dout", int'(data_out), 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(1, 0, 0, 8'h11); chk_model("post_rst.w");
    cyc(0, 1, 0, 8'h00); chk_model("post_rst.r");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
